pc_fetch_unit: RTL and testbench

- Instruction-fetch stage of the 32-bit MIPS core. Directly downstream of the next-PC 2:1 mux: the mux selects the branch or jump target, and this block consumes the selected target.
- Holds the PC and issues requests to instruction memory over a req/ready handshake.
- Presents each fetched instruction and its PC+4 to decode through a valid/ready output register, with redirect flush.

---
 rtl/mips_pkg.sv | 11 +
 rtl/pc_fetch_unit_pc_reg.sv | 41 ++++
 rtl/pc_fetch_unit.sv | 75 +++++++
 tb/tb_pc_fetch_unit.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// mips_pkg: shared types and constants for the MIPS instruction-fetch stage.
//   fetch_state_t : fetch FSM states {IDLE, FETCH, WAIT, REDIR}
//   word_t        : 32-bit datapath word
//   INSTR_BYTES   : PC increment per instruction
//   NOP_INSTR     : instruction word held in the decode register after reset
package mips_pkg;
  typedef logic [31:0] word_t;
  typedef enum logic [1:0] {IDLE, FETCH, WAIT, REDIR} fetch_state_t;
  localparam word_t INSTR_BYTES = 32'd4;
  localparam word_t NOP_INSTR   = 32'h0;
endpackage

// File: rtl/pc_fetch_unit_pc_reg.sv
// pc_reg: program counter with increment, redirect load and optional alignment check.
//   clk, rst_n  : clock, asynchronous active-low reset (PC <- RESET_PC)
//   i_inc       : advance PC by one instruction (32-bit wrap)
//   i_load      : load i_load_pc, takes priority over i_inc
//   i_load_pc   : redirect target
//   o_pc        : current PC
//   o_addr_err  : sticky misaligned-redirect flag (only with PC_ALIGN_CHECK_EN)
// Macro PC_ALIGN_CHECK_EN: force loaded PC to word alignment and flag misaligned targets.
module pc_reg
  import mips_pkg::*;
#(
  parameter word_t RESET_PC = 32'h0000_0000
) (
  input  logic  clk,
  input  logic  rst_n,
  input  logic  i_inc,
  input  logic  i_load,
  input  word_t i_load_pc,
`ifdef PC_ALIGN_CHECK_EN
  output logic  o_addr_err,
`endif
  output word_t o_pc
);
  word_t r_pc;
  word_t w_load_pc;
`ifdef PC_ALIGN_CHECK_EN
  logic r_addr_err;
  assign w_load_pc  = {i_load_pc[31:2], 2'b00};
  assign o_addr_err = r_addr_err;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_addr_err <= 1'b0;
    else if (i_load && |i_load_pc[1:0]) r_addr_err <= 1'b1;
`else
  assign w_load_pc = i_load_pc;
`endif
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_pc <= RESET_PC;
    else if (i_load) r_pc <= w_load_pc;
    else if (i_inc) r_pc <= r_pc + INSTR_BYTES;
  assign o_pc = r_pc;
endmodule

// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: MIPS instruction-fetch stage (PC, imem req/ready, decode output register).
//   clk, rst_n             : clock, asynchronous active-low reset
//   redirect_i/_pc_i       : one-cycle branch/jump redirect and its target
//   imem_req_o/_addr_o     : fetch request and address (address is the PC)
//   imem_ready_i/_rdata_i  : memory accept and same-cycle instruction word
//   if_valid_o/_instr_o/_pc4_o : decode output register
//   id_ready_i             : decode consumes the output register
//   addr_err_o             : sticky misaligned-redirect flag (only with PC_ALIGN_CHECK_EN)
// Macro PC_ALIGN_CHECK_EN enables the alignment check inside pc_reg.
module pc_fetch_unit
  import mips_pkg::*;
#(
  parameter word_t RESET_PC = 32'h0000_0000,
  parameter int    XLEN     = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            redirect_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  output logic            imem_req_o,
  output logic [XLEN-1:0] imem_addr_o,
  input  logic            imem_ready_i,
  input  logic [XLEN-1:0] imem_rdata_i,
  output logic            if_valid_o,
  output logic [XLEN-1:0] if_instr_o,
  output logic [XLEN-1:0] if_pc4_o,
`ifdef PC_ALIGN_CHECK_EN
  output logic            addr_err_o,
`endif
  input  logic            id_ready_i
);
  fetch_state_t r_state, w_next;
  word_t w_pc;
  logic w_slot_free, w_accept;
  assign w_slot_free = !if_valid_o || id_ready_i;
  // a response coinciding with a redirect belongs to the old path and is dropped
  assign w_accept    = imem_req_o && imem_ready_i && !redirect_i;
  pc_reg #(.RESET_PC(RESET_PC)) u_pc_reg (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_inc     (w_accept),
    .i_load    (redirect_i),
    .i_load_pc (redirect_pc_i),
`ifdef PC_ALIGN_CHECK_EN
    .o_addr_err(addr_err_o),
`endif
    .o_pc      (w_pc)
  );
  assign imem_addr_o = w_pc;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= IDLE;
    else r_state <= w_next;
  always_comb
    w_next = redirect_i ? REDIR :
             (r_state == IDLE || r_state == REDIR) ? FETCH :
             (r_state == FETCH) ? ((imem_req_o && !imem_ready_i) ? WAIT : FETCH) :
             (imem_ready_i ? FETCH : WAIT);
  // a WAIT request was started with the slot free, so it never needs re-gating
  always_comb
    imem_req_o = (r_state == FETCH) ? w_slot_free : (r_state == WAIT);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      if_valid_o <= 1'b0;
      if_instr_o <= NOP_INSTR;
      if_pc4_o   <= '0;
    end else if (redirect_i) begin
      if_valid_o <= 1'b0;
    end else if (w_accept) begin
      if_valid_o <= 1'b1;
      if_instr_o <= imem_rdata_i;
      if_pc4_o   <= w_pc + INSTR_BYTES;
    end else if (id_ready_i) begin
      if_valid_o <= 1'b0;
    end
endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb_pc_fetch_unit: directed and randomized checks of pc_fetch_unit against a behavioural model.
module tb_pc_fetch_unit;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        redirect_i = 1'b0;
  logic [31:0] redirect_pc_i = '0;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_ready_i = 1'b0;
  logic [31:0] imem_rdata_i;
  logic        if_valid_o;
  logic [31:0] if_instr_o;
  logic [31:0] if_pc4_o;
  logic        id_ready_i = 1'b0;
`ifdef PC_ALIGN_CHECK_EN
  logic        addr_err_o;
`endif

  pc_fetch_unit dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .redirect_i   (redirect_i),
    .redirect_pc_i(redirect_pc_i),
    .imem_req_o   (imem_req_o),
    .imem_addr_o  (imem_addr_o),
    .imem_ready_i (imem_ready_i),
    .imem_rdata_i (imem_rdata_i),
    .if_valid_o   (if_valid_o),
    .if_instr_o   (if_instr_o),
    .if_pc4_o     (if_pc4_o),
`ifdef PC_ALIGN_CHECK_EN
    .addr_err_o   (addr_err_o),
`endif
    .id_ready_i   (id_ready_i)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction
  assign imem_rdata_i = mem(imem_addr_o);

  int n_checks = 0;
  int n_errors = 0;

  // Model: pc, decode register contents, number of dead cycles before the
  // fetcher may request again, and whether a request is outstanding.
  logic [31:0] m_pc, m_instr, m_pc4;
  bit          m_valid, m_out, m_req, m_err;
  int          m_bubble;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    #1;
    check("rst_req", {31'b0, imem_req_o}, 32'h0);
    check("rst_valid", {31'b0, if_valid_o}, 32'h0);
    check("rst_instr", if_instr_o, 32'h0);
    check("rst_pc4", if_pc4_o, 32'h0);
    check("rst_addr", imem_addr_o, 32'h0);
`ifdef PC_ALIGN_CHECK_EN
    check("rst_err", {31'b0, addr_err_o}, 32'h0);
`endif
    m_pc = 32'h0; m_valid = 0; m_instr = 32'h0; m_pc4 = 32'h0;
    m_bubble = 1; m_out = 0; m_err = 0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic step(input bit rdy, input bit idr, input bit redir, input logic [31:0] rpc);
    imem_ready_i = rdy; id_ready_i = idr; redirect_i = redir; redirect_pc_i = rpc;
    m_req = (m_bubble == 0) && (m_out || !m_valid || idr);
    #1;
    check("req", {31'b0, imem_req_o}, {31'b0, m_req});
    check("addr", imem_addr_o, m_pc);
    check("valid", {31'b0, if_valid_o}, {31'b0, m_valid});
    if (m_valid) begin
      check("instr", if_instr_o, m_instr);
      check("pc4", if_pc4_o, m_pc4);
    end
`ifdef PC_ALIGN_CHECK_EN
    check("err", {31'b0, addr_err_o}, {31'b0, m_err});
`endif
    if (redir) begin
`ifdef PC_ALIGN_CHECK_EN
      m_pc = rpc & 32'hFFFF_FFFC;
      if (rpc[1:0] != 2'b00) m_err = 1;
`else
      m_pc = rpc;
`endif
      m_valid = 0; m_bubble = 1; m_out = 0;
    end else if (m_bubble > 0) begin
      m_bubble--;
      if (idr) m_valid = 0;
    end else if (m_req && rdy) begin
      m_instr = mem(m_pc); m_pc4 = m_pc + 32'd4; m_valid = 1;
      m_pc = m_pc + 32'd4; m_out = 0;
    end else begin
      if (idr) m_valid = 0;
      m_out = m_req;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    logic [31:0] rpc;
    @(negedge clk);
    do_reset;
    repeat (6) step(1, 1, 0, 0);
    do_reset;
    repeat (3) step(1, 1, 0, 0);
    repeat (3) step(0, 1, 0, 0);
    step(1, 1, 0, 0);
    step(1, 1, 0, 0);
    repeat (4) step(1, 0, 0, 0);
    repeat (2) step(1, 1, 0, 0);
    step(1, 1, 1, 32'h10);
    step(1, 1, 0, 0);
    step(0, 1, 0, 0);
    step(1, 1, 1, 32'h400);
    repeat (3) step(1, 1, 0, 0);
    step(1, 1, 1, 32'hFFFF_FFFC);
    repeat (3) step(1, 1, 0, 0);
    do_reset;
    step(1, 1, 1, 32'h80);
    repeat (2) step(1, 1, 0, 0);
    step(1, 1, 1, 32'h100);
    step(1, 1, 1, 32'h200);
    repeat (3) step(1, 1, 0, 0);
`ifdef PC_ALIGN_CHECK_EN
    step(1, 1, 1, 32'h402);
    repeat (4) step(1, 1, 0, 0);
    do_reset;
    repeat (2) step(1, 1, 0, 0);
`endif
    repeat (400) begin
      rpc = $urandom;
`ifndef PC_ALIGN_CHECK_EN
      rpc = rpc & 32'hFFFF_FFFC;
`endif
      step($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0, $urandom_range(0, 99) < 6, rpc);
    end
    step(0, 1, 1, 32'h40);
    repeat (2) step(0, 1, 0, 0);
    #1;
    check("wait_req", {31'b0, imem_req_o}, 32'h1);
    do_reset;
    repeat (3) step(1, 1, 0, 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
